// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the multiplexed seven-segment scanner.
package seg_scan_pkg;

    typedef enum logic {GAP, SHOW} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'h00;

    // Active-low g..a patterns indexed by hex value.
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_ctrl_hex7.sv
// hex7seg_decode: combinational nibble to active-low seven-segment pattern.
module hex7seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = HEX7[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit scan with anti-ghost blanking and a frame-aligned
// double buffer so an update never tears across a frame.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int SLOT_FREQ  = 1_000,
    parameter int GAP_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic [7:0]  disp_dp,
    input  logic [7:0]  disp_en,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [7:0]  seg,
    output logic [7:0]  sel,
    output logic        frame_done
);

    localparam int SLOT_CNT = CLOCK_FREQ / SLOT_FREQ;
    localparam int CW = $clog2(SLOT_CNT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [7:0]    seg_q, seg_d, sel_q, sel_d;
    logic          frame_done_q, frame_done_d;
    logic          upd_ready_q, upd_ready_d;
    disp_t         act_q, act_d, pend_q, pend_d;
    logic          wrap, boundary, accept, show_on;
    logic [3:0]    nib;
    logic [6:0]    pat;

    assign nib = act_q.data[{idx_q, 2'b00} +: 4];

    hex7seg_decode u_dec (
        .nib(nib),
        .pat(pat)
    );

    always_comb begin
        wrap         = cnt_q == CW'(SLOT_CNT - 1);
        boundary     = wrap && idx_q == 3'd7;
        accept       = upd_valid && upd_ready_q;
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = wrap ? idx_q + 1'b1 : idx_q;
        state_d      = wrap ? GAP : (cnt_q == CW'(GAP_CYCLES - 1)) ? SHOW : state_q;
        show_on      = state_d == SHOW && act_q.en[idx_q];
        sel_d        = show_on ? 8'h01 << idx_q : SEL_OFF;
        seg_d        = show_on ? {~act_q.dp[idx_q], pat} : SEG_OFF;
        // An empty pending buffer is exactly upd_ready high.
        act_d        = (boundary && !upd_ready_q) ? pend_q : act_q;
        pend_d       = accept ? {disp_data, disp_dp, disp_en} : pend_q;
        upd_ready_d  = accept ? 1'b0 : boundary ? 1'b1 : upd_ready_q;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= GAP;
            seg_q        <= SEG_OFF;
            sel_q        <= SEL_OFF;
            frame_done_q <= 1'b0;
            upd_ready_q  <= 1'b1;
            act_q        <= '0;
            pend_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            upd_ready_q  <= upd_ready_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
        end
    end

    assign seg        = seg_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;
    assign upd_ready  = upd_ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table vectors, directed corner sequences and random traffic
// checked every cycle against a time-based model of the scanner.
module tb_seg_scan_ctrl;

    localparam int GAP = 2;
    localparam int SC  = 8;
    localparam int FR  = 64;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  dp;
        logic [7:0]  en;
    } set_t;

    typedef struct {
        set_t       s;
        int         slot;
        logic [7:0] sel;
        logic [7:0] seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] disp_data;
    logic [7:0]  disp_dp, disp_en, seg, sel;
    logic        upd_valid, upd_ready, frame_done;

    logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] seg_a [8] = '{8'h40, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] seg_b [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    set_t act;
    set_t pend[$];
    int   n;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tv [16];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLOCK_FREQ(800), .SLOT_FREQ(100), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .disp_data(disp_data), .disp_dp(disp_dp),
        .disp_en(disp_en), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .seg(seg), .sel(sel), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, got, exp, n);
        end
    endtask

    // One clock: advance the model from the inputs seen at the edge, then compare.
    task automatic tick();
        logic r, v, rdy, on;
        set_t s;
        int pos, dig;
        logic [7:0] es, el;
        r = reset;
        v = upd_valid;
        s = {disp_data, disp_dp, disp_en};
        @(posedge clk);
        #1;
        if (r) begin
            n = 0;
            act = '0;
            pend.delete();
        end else begin
            rdy = pend.size() == 0;
            if (n % FR == FR - 1 && !rdy) act = pend.pop_front();
            if (v && rdy) pend.push_back(s);
            n++;
        end
        pos = n % SC;
        dig = (n / SC) % 8;
        on  = pos >= GAP && act.en[dig];
        el  = on ? 8'(1 << dig) : 8'h00;
        es  = on ? {~act.dp[dig], hex_lut[act.d[dig*4 +: 4]]} : 8'hFF;
        chk("sel", {24'd0, sel}, {24'd0, el});
        chk("seg", {24'd0, seg}, {24'd0, es});
        chk("upd_ready", {31'd0, upd_ready}, {31'd0, pend.size() == 0});
        chk("frame_done", {31'd0, frame_done}, {31'd0, n > 0 && n % FR == 0});
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        do begin
            tick();
            k++;
        end while (n % FR != p && k < 200);
        if (n % FR != p) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos: position %0d required %0d", n % FR, p);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!upd_ready && k < 200) begin
            tick();
            k++;
        end
        if (!upd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready: upd_ready %b required 1", upd_ready);
        end
    endtask

    task automatic drive(input set_t s);
        {disp_data, disp_dp, disp_en} = s;
    endtask

    task automatic offer(input set_t s);
        wait_ready();
        drive(s);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        set_t sa, sb, s1, s2, s3, sd, se, sf, sg;
        int bad, t0;
        sa = {32'h7654_3210, 8'h01, 8'hFF};
        sb = {32'hFEDC_BA98, 8'h00, 8'hFF};
        s1 = {32'h1111_1111, 8'h00, 8'hFF};
        s2 = {32'h2222_2222, 8'h00, 8'hFF};
        s3 = {32'h3333_3333, 8'h00, 8'hFF};
        sd = {32'h0000_0000, 8'h00, 8'hAA};
        se = {32'h8888_8888, 8'hFF, 8'hFF};
        sf = {32'h1111_1111, 8'h00, 8'hFF};
        sg = {32'h2222_2222, 8'h00, 8'hFF};
        for (int k = 0; k < 8; k++) begin
            tv[k]     = '{sa, k, 8'(1 << k), seg_a[k]};
            tv[k + 8] = '{sb, k, 8'(1 << k), seg_b[k]};
        end
        reset = 1'b1;
        upd_valid = 1'b0;
        drive('0);
        tick();
        tick();
        chk("rst_sel", {24'd0, sel}, 32'h00);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_rdy", {31'd0, upd_ready}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) chk("gap_seg", {24'd0, seg}, 32'hFF);
            if (sel !== 8'h00) bad++;
        end
        chk("frame0_blank", bad, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || tv[i].s != tv[i - 1].s) begin
                offer(tv[i].s);
                wait_pos(0);
            end
            wait_pos(tv[i].slot * SC + GAP + 1);
            chk("tv_sel", {24'd0, sel}, {24'd0, tv[i].sel});
            chk("tv_seg", {24'd0, seg}, {24'd0, tv[i].seg});
        end
        wait_ready();
        drive(s1);
        upd_valid = 1'b1;
        tick();
        chk("hold_rdy_low", {31'd0, upd_ready}, 32'd0);
        drive(s2);
        wait_pos(0);
        chk("rdy_rerise", {31'd0, upd_ready}, 32'd1);
        tick();
        chk("second_accept", {31'd0, upd_ready}, 32'd0);
        upd_valid = 1'b0;
        wait_pos(3);
        chk("hold_first_seg", {24'd0, seg}, 32'hF9);
        chk("hold_first_sel", {24'd0, sel}, 32'h01);
        wait_pos(0);
        wait_pos(3);
        chk("hold_second_seg", {24'd0, seg}, 32'hA4);
        wait_pos(63);
        drive(s3);
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("bnd_fd", {31'd0, frame_done}, 32'd1);
        chk("bnd_rdy", {31'd0, upd_ready}, 32'd0);
        t0 = n;
        wait_pos(3);
        chk("bnd_old_seg", {24'd0, seg}, 32'hA4);
        wait_pos(0);
        chk("fd_spacing", n - t0, 64);
        wait_pos(3);
        chk("bnd_new_seg", {24'd0, seg}, 32'hB0);
        offer(sd);
        wait_pos(0);
        t0 = n;
        for (int s = 0; s < 8; s++) begin
            wait_pos(s * SC + 3);
            chk("en_sel", {24'd0, sel}, (s % 2 == 1) ? 32'(1 << s) : 32'h00);
            chk("en_seg", {24'd0, seg}, (s % 2 == 1) ? 32'hC0 : 32'hFF);
        end
        wait_pos(0);
        chk("en_frame_len", n - t0, 64);
        offer(se);
        wait_pos(0);
        offer(sf);
        wait_pos(27);
        reset = 1'b1;
        drive(sg);
        upd_valid = 1'b1;
        tick();
        chk("mid_rst_sel", {24'd0, sel}, 32'h00);
        chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
        chk("mid_rst_rdy", {31'd0, upd_ready}, 32'd1);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
        tick();
        reset = 1'b0;
        upd_valid = 1'b0;
        drive(sf);
        bad = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            tick();
            if (sel !== 8'h00) bad++;
        end
        chk("post_rst_blank", bad, 0);
        for (int k = 0; k < 800; k++) begin
            upd_valid = ($urandom % 4) == 0;
            drive({32'($urandom), 8'($urandom), 8'($urandom)});
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
